// File: rtl/ice51_mem_arb_if.sv
// Requester and memory-side bus of the shared-SRAM arbiter, one flat bus per direction.
// Channel c occupies bits [c*ADDR_W +: ADDR_W] of i_addr and [c*DATA_W +: DATA_W] of i_wdata.
interface ice51_mem_arb_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic [NUM_CH-1:0]        i_req;
    logic [NUM_CH-1:0]        i_we;
    logic [NUM_CH*ADDR_W-1:0] i_addr;
    logic [NUM_CH*DATA_W-1:0] i_wdata;
    logic [NUM_CH-1:0]        o_gnt;
    logic [NUM_CH-1:0]        o_rvalid;
    logic [DATA_W-1:0]        o_rdata;
    logic                     o_mem_we;
    logic [ADDR_W-1:0]        o_mem_addr;
    logic [DATA_W-1:0]        o_mem_wdata;
    logic [DATA_W-1:0]        i_mem_rdata;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_mem_rdata,
        output o_gnt, o_rvalid, o_rdata, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_mem_rdata,
        input  o_gnt, o_rvalid, o_rdata, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/ice51_mem_arb.sv
// N-channel fixed-priority / round-robin arbiter in front of one single-port sync SRAM.
// Grant is combinational; read data returns 1 (PIPE=0) or 2 (PIPE=1) cycles after grant; ungranted requesters simply hold.
module ice51_mem_arb #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int MODE   = 1,
    parameter int PIPE   = 0
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    ice51_mem_arb_if.slave bus
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  win;
    logic              found;
    logic [NUM_CH-1:0] gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [NUM_CH-1:0] rd_tag;
    logic [NUM_CH-1:0] tag_d;
    logic [NUM_CH-1:0] rvalid_q;

    // First pass only looks at channels at or above the pointer (all of them in
    // fixed-priority mode); the second pass picks up the wrap-around.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!found && bus.i_req[c] && (MODE == 0 || c >= int'(ptr))) begin
                gnt[c] = 1'b1;
                win    = PTR_W'(c);
                found  = 1'b1;
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!found && bus.i_req[c]) begin
                gnt[c] = 1'b1;
                win    = PTR_W'(c);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt[c]) begin
                sel_we    = bus.i_we[c];
                sel_addr  = bus.i_addr[c*ADDR_W +: ADDR_W];
                sel_wdata = bus.i_wdata[c*DATA_W +: DATA_W];
            end
        end
    end

    assign rd_tag = (found && !sel_we) ? gnt : '0;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (win == PTR_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
        end
    end

    generate
        if (PIPE != 0) begin : g_pipe
            logic              mem_we_q;
            logic [ADDR_W-1:0] mem_addr_q;
            logic [DATA_W-1:0] mem_wdata_q;
            logic [NUM_CH-1:0] tag_q;

            always_ff @(posedge i_clk or negedge i_nrst) begin
                if (!i_nrst) begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    tag_q       <= '0;
                end else begin
                    mem_we_q    <= sel_we;
                    mem_addr_q  <= sel_addr;
                    mem_wdata_q <= sel_wdata;
                    tag_q       <= rd_tag;
                end
            end

            assign bus.o_mem_we    = mem_we_q;
            assign bus.o_mem_addr  = mem_addr_q;
            assign bus.o_mem_wdata = mem_wdata_q;
            assign tag_d           = tag_q;
        end else begin : g_comb
            // Grant stays live in reset, so the write strobe must be masked here.
            assign bus.o_mem_we    = sel_we & i_nrst;
            assign bus.o_mem_addr  = sel_addr;
            assign bus.o_mem_wdata = sel_wdata;
            assign tag_d           = rd_tag;
        end
    endgenerate

    // Final tag stage lines up with the SRAM's one-cycle read latency.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= tag_d;
        end
    end

    assign bus.o_gnt    = gnt;
    assign bus.o_rvalid = rvalid_q;
    assign bus.o_rdata  = bus.i_mem_rdata;
endmodule

// File: tb/tb_ice51_mem_arb.sv
// Bench for ice51_mem_arb: A = 3 ch round robin, PIPE=0; B = 2 ch fixed priority, PIPE=1.
// Vector table, directed corner sequences, then random traffic against a reference model.
module tb_ice51_mem_arb;
    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    always #5 clk = ~clk;

    ice51_mem_arb_if #(.NUM_CH(3), .ADDR_W(10), .DATA_W(8)) ifa ();
    ice51_mem_arb_if #(.NUM_CH(2), .ADDR_W(10), .DATA_W(8)) ifb ();

    ice51_mem_arb #(.NUM_CH(3), .ADDR_W(10), .DATA_W(8), .MODE(1), .PIPE(0))
        dut_a (.i_clk(clk), .i_nrst(rst_n), .bus(ifa.slave));
    ice51_mem_arb #(.NUM_CH(2), .ADDR_W(10), .DATA_W(8), .MODE(0), .PIPE(1))
        dut_b (.i_clk(clk), .i_nrst(rst_n), .bus(ifb.slave));

    logic [7:0] mem_a [1024];
    logic [7:0] mem_b [1024];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) begin
                mem_a[i] <= 8'(i) ^ 8'h5A;
                mem_b[i] <= 8'(i) ^ 8'h5A;
            end
        end else begin
            if (ifa.o_mem_we) mem_a[ifa.o_mem_addr] <= ifa.o_mem_wdata;
            if (ifb.o_mem_we) mem_b[ifb.o_mem_addr] <= ifb.o_mem_wdata;
            ifa.i_mem_rdata <= mem_a[ifa.o_mem_addr];
            ifb.i_mem_rdata <= mem_b[ifb.o_mem_addr];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ifa.i_req = '0; ifa.i_we = '0; ifa.i_addr = '0; ifa.i_wdata = '0;
        ifb.i_req = '0; ifb.i_we = '0; ifb.i_addr = '0; ifb.i_wdata = '0;
    endtask

    // ---------------- reference model ----------------
    int         ptr_m   [2];
    logic [2:0] slot_ch [2][4];
    logic [7:0] slot_dat[2][4];
    logic       pw_m    [2];
    logic [9:0] pa_m    [2];
    logic [7:0] pd_m    [2];
    logic [7:0] sh      [2][1024];
    logic [2:0] mgnt    [2];
    int         cyc;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ptr_m[d] = 0; pw_m[d] = 1'b0; pa_m[d] = '0; pd_m[d] = '0; mgnt[d] = '0;
            for (int s = 0; s < 4; s++) begin slot_ch[d][s] = '0; slot_dat[d][s] = '0; end
            for (int i = 0; i < 1024; i++) sh[d][i] = 8'(i) ^ 8'h5A;
        end
        cyc = 0;
    endtask

    task automatic model_step(input int d, input int nch, input int mode, input int pipe,
                              input logic [2:0] req, input logic [2:0] we,
                              input logic [29:0] addr, input logic [23:0] wd,
                              input logic [2:0] a_gnt, input logic [2:0] a_rv, input logic [7:0] a_rd,
                              input logic a_mwe, input logic [9:0] a_madr, input logic [7:0] a_mwd);
        int w;
        int c;
        int s;
        string dn;
        logic [2:0] egnt;
        logic ew;
        logic [9:0] ea;
        logic [7:0] ed;
        dn = (d == 0) ? "A" : "B";
        w = -1;
        for (int k = 0; k < nch; k++) begin
            c = (mode == 0) ? k : (ptr_m[d] + k) % nch;
            if (w < 0 && req[c]) w = c;
        end
        egnt = (w < 0) ? 3'b000 : 3'(1 << w);
        ew = (w < 0) ? 1'b0 : we[w];
        ea = (w < 0) ? 10'h0 : addr[w*10 +: 10];
        ed = (w < 0) ? 8'h0 : wd[w*8 +: 8];
        chk({dn, " rnd gnt"}, 32'(a_gnt), 32'(egnt));
        chk({dn, " rnd mem_we"},    32'(a_mwe),  32'(pipe != 0 ? pw_m[d] : ew));
        chk({dn, " rnd mem_addr"},  32'(a_madr), 32'(pipe != 0 ? pa_m[d] : ea));
        chk({dn, " rnd mem_wdata"}, 32'(a_mwd),  32'(pipe != 0 ? pd_m[d] : ed));
        s = cyc % 4;
        chk({dn, " rnd rvalid"}, 32'(a_rv), 32'(slot_ch[d][s]));
        if (slot_ch[d][s] != 0) chk({dn, " rnd rdata"}, 32'(a_rd), 32'(slot_dat[d][s]));
        slot_ch[d][s] = '0;
        if (w >= 0) begin
            ptr_m[d] = (w + 1) % nch;
            if (ew) sh[d][ea] = ed;
            else begin
                s = (cyc + 1 + pipe) % 4;
                slot_ch[d][s]  = egnt;
                slot_dat[d][s] = sh[d][ea];
            end
        end
        pw_m[d] = ew; pa_m[d] = ea; pd_m[d] = ed;
        mgnt[d] = egnt;
    endtask

    // ---------------- vector table for A ----------------
    typedef struct {
        logic [2:0] req;
        logic [2:0] gnt;
        logic [2:0] rv;
        logic [9:0] maddr;
    } vec_t;

    function automatic vec_t mkv(input logic [2:0] req, input logic [2:0] gnt, input logic [2:0] rv);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv;
        v.maddr = gnt[0] ? 10'h100 : gnt[1] ? 10'h101 : gnt[2] ? 10'h102 : 10'h000;
        return v;
    endfunction

    vec_t tbl [14];

    logic pend [2][3];
    logic pwe  [2][3];
    logic [9:0] padr [2][3];
    logic [7:0] pwd  [2][3];

    initial begin
        rst_n = 1'b0;
        clr   = 1'b1;
        idle_all();

        // reset state; grant still follows request while in reset
        step();
        clr = 1'b0;
        ifa.i_req = 3'b010; ifa.i_we = 3'b010; ifa.i_addr = {10'h102, 10'h101, 10'h100};
        @(negedge clk);
        chk("A reset gnt",    32'(ifa.o_gnt),    32'h2);
        chk("A reset mem_we", 32'(ifa.o_mem_we), 32'h0);
        chk("A reset rvalid", 32'(ifa.o_rvalid), 32'h0);
        chk("B reset rvalid", 32'(ifb.o_rvalid), 32'h0);
        chk("B reset mem_we", 32'(ifb.o_mem_we), 32'h0);
        chk("B reset addr",   32'(ifb.o_mem_addr), 32'h0);
        step();
        idle_all();
        rst_n = 1'b1;
        @(negedge clk);
        chk("A post-reset rvalid", 32'(ifa.o_rvalid), 32'h0);

        // round-robin table on A, all reads
        tbl[0]  = mkv(3'b111, 3'b001, 3'b000);
        tbl[1]  = mkv(3'b111, 3'b010, 3'b001);
        tbl[2]  = mkv(3'b111, 3'b100, 3'b010);
        tbl[3]  = mkv(3'b111, 3'b001, 3'b100);
        tbl[4]  = mkv(3'b111, 3'b010, 3'b001);
        tbl[5]  = mkv(3'b111, 3'b100, 3'b010);
        tbl[6]  = mkv(3'b000, 3'b000, 3'b100);
        tbl[7]  = mkv(3'b110, 3'b010, 3'b000);
        tbl[8]  = mkv(3'b011, 3'b001, 3'b010);
        tbl[9]  = mkv(3'b101, 3'b100, 3'b001);
        tbl[10] = mkv(3'b100, 3'b100, 3'b100);
        tbl[11] = mkv(3'b111, 3'b001, 3'b100);
        tbl[12] = mkv(3'b010, 3'b010, 3'b001);
        tbl[13] = mkv(3'b111, 3'b100, 3'b010);
        ifa.i_addr = {10'h102, 10'h101, 10'h100};
        for (int i = 0; i < 14; i++) begin
            step();
            ifa.i_req = tbl[i].req;
            @(negedge clk);
            chk($sformatf("tbl%0d gnt", i),    32'(ifa.o_gnt),      32'(tbl[i].gnt));
            chk($sformatf("tbl%0d rvalid", i), 32'(ifa.o_rvalid),   32'(tbl[i].rv));
            chk($sformatf("tbl%0d maddr", i),  32'(ifa.o_mem_addr), 32'(tbl[i].maddr));
            chk($sformatf("tbl%0d mem_we", i), 32'(ifa.o_mem_we),   32'h0);
        end
        step();
        idle_all();
        @(negedge clk);
        chk("tbl tail rvalid", 32'(ifa.o_rvalid), 32'h4);

        // single write then read on A ch0
        step();
        ifa.i_req = 3'b001; ifa.i_we = 3'b001; ifa.i_addr = 30'h012; ifa.i_wdata = 24'hA5;
        @(negedge clk);
        chk("A wr gnt",   32'(ifa.o_gnt),       32'h1);
        chk("A wr we",    32'(ifa.o_mem_we),    32'h1);
        chk("A wr addr",  32'(ifa.o_mem_addr),  32'h012);
        chk("A wr data",  32'(ifa.o_mem_wdata), 32'hA5);
        step();
        ifa.i_we = 3'b000;
        @(negedge clk);
        chk("A rd gnt",   32'(ifa.o_gnt),    32'h1);
        chk("A rd we",    32'(ifa.o_mem_we), 32'h0);
        chk("A rd early rvalid", 32'(ifa.o_rvalid), 32'h0);
        step();
        idle_all();
        @(negedge clk);
        chk("A rd rvalid", 32'(ifa.o_rvalid), 32'h1);
        chk("A rd rdata",  32'(ifa.o_rdata),  32'hA5);
        chk("A idle we",   32'(ifa.o_mem_we), 32'h0);
        chk("A idle addr", 32'(ifa.o_mem_addr), 32'h0);
        chk("A idle wdata", 32'(ifa.o_mem_wdata), 32'h0);

        // fixed priority on B, ch1 starved until ch0 drops
        step();
        ifb.i_req = 2'b11; ifb.i_we = 2'b11; ifb.i_addr = {10'h021, 10'h020}; ifb.i_wdata = {8'h22, 8'h11};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("B prio gnt%0d", i), 32'(ifb.o_gnt), 32'h1);
            step();
        end
        ifb.i_req = 2'b10;
        @(negedge clk);
        chk("B prio ch1 gnt", 32'(ifb.o_gnt), 32'h2);
        step();
        idle_all();
        @(negedge clk);
        chk("B piped we",   32'(ifb.o_mem_we),    32'h1);
        chk("B piped addr", 32'(ifb.o_mem_addr),  32'h021);
        chk("B piped data", 32'(ifb.o_mem_wdata), 32'h22);

        // PIPE=1 back-to-back reads on B
        step();
        ifb.i_req = 2'b10; ifb.i_we = 2'b10; ifb.i_addr = {10'h3FF, 10'h000}; ifb.i_wdata = {8'hC3, 8'h3C};
        step();
        ifb.i_req = 2'b01; ifb.i_we = 2'b01;
        step();
        ifb.i_req = 2'b10; ifb.i_we = 2'b00;
        @(negedge clk);
        chk("B b2b gnt1", 32'(ifb.o_gnt), 32'h2);
        step();
        ifb.i_req = 2'b01;
        @(negedge clk);
        chk("B b2b gnt0",     32'(ifb.o_gnt),      32'h1);
        chk("B b2b rvalid+1", 32'(ifb.o_rvalid),   32'h0);
        chk("B b2b maddr+1",  32'(ifb.o_mem_addr), 32'h3FF);
        step();
        idle_all();
        @(negedge clk);
        chk("B b2b rvalid+2", 32'(ifb.o_rvalid), 32'h2);
        chk("B b2b rdata+2",  32'(ifb.o_rdata),  32'hC3);
        step();
        @(negedge clk);
        chk("B b2b rvalid+3", 32'(ifb.o_rvalid), 32'h1);
        chk("B b2b rdata+3",  32'(ifb.o_rdata),  32'h3C);

        // reset while reads are in flight on both
        step();
        ifa.i_req = 3'b010; ifa.i_addr = {10'h0, 10'h055, 10'h0};
        ifb.i_req = 2'b01;  ifb.i_addr = 20'h3FF;
        @(negedge clk);
        chk("A rst-rd gnt", 32'(ifa.o_gnt), 32'h2);
        step();
        rst_n = 1'b0;
        idle_all();
        @(negedge clk);
        chk("A rst-rd rvalid", 32'(ifa.o_rvalid), 32'h0);
        chk("B rst-rd rvalid", 32'(ifb.o_rvalid), 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("A after-rst rvalid%0d", i), 32'(ifa.o_rvalid), 32'h0);
            chk($sformatf("B after-rst rvalid%0d", i), 32'(ifb.o_rvalid), 32'h0);
            step();
        end
        ifa.i_req = 3'b111;
        @(negedge clk);
        chk("A after-rst first gnt", 32'(ifa.o_gnt), 32'h1);

        // withdrawal on A: ch0 waits behind ch1, then drops its write
        step();
        ifa.i_req = 3'b011; ifa.i_we = 3'b001;
        ifa.i_addr = {10'h0, 10'h055, 10'h040}; ifa.i_wdata = 24'h77;
        @(negedge clk);
        chk("A wdr gnt", 32'(ifa.o_gnt), 32'h2);
        step();
        ifa.i_req = 3'b000;
        @(negedge clk);
        chk("A wdr gnt0",   32'(ifa.o_gnt),      32'h0);
        chk("A wdr we",     32'(ifa.o_mem_we),   32'h0);
        chk("A wdr addr",   32'(ifa.o_mem_addr), 32'h0);
        chk("A wdr rvalid", 32'(ifa.o_rvalid),   32'h2);
        chk("A wdr rdata",  32'(ifa.o_rdata),    32'h0F);
        step();
        ifa.i_req = 3'b100; ifa.i_we = 3'b000; ifa.i_addr = {10'h040, 10'h0, 10'h0};
        @(negedge clk);
        chk("A wdr quiet rvalid", 32'(ifa.o_rvalid), 32'h0);
        step();
        idle_all();
        @(negedge clk);
        chk("A wdr untouched rvalid", 32'(ifa.o_rvalid), 32'h4);
        chk("A wdr untouched rdata",  32'(ifa.o_rdata),  32'h1A);

        // random traffic on both against the model
        step();
        rst_n = 1'b0;
        clr   = 1'b1;
        step();
        clr   = 1'b0;
        rst_n = 1'b1;
        model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++) begin
                pend[d][c] = 1'b0; pwe[d][c] = 1'b0; padr[d][c] = '0; pwd[d][c] = '0;
            end
        for (int n = 0; n < 3000; n++) begin
            if (n != 0) step();
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 3 - d; c++) begin
                    logic withdrew;
                    withdrew = 1'b0;
                    if (pend[d][c] && mgnt[d][c]) pend[d][c] = 1'b0;
                    else if (pend[d][c] && $urandom_range(0, 7) == 0) begin
                        pend[d][c] = 1'b0;
                        withdrew   = 1'b1;
                    end
                    if (!pend[d][c] && !withdrew && $urandom_range(0, 2) != 0) begin
                        pend[d][c] = 1'b1;
                        pwe[d][c]  = 1'($urandom_range(0, 1));
                        padr[d][c] = 10'($urandom_range(0, 15));
                        pwd[d][c]  = 8'($urandom);
                    end
                end
            end
            for (int c = 0; c < 3; c++) begin
                ifa.i_req[c] = pend[0][c];
                ifa.i_we[c]  = pwe[0][c];
                ifa.i_addr[c*10 +: 10] = padr[0][c];
                ifa.i_wdata[c*8 +: 8]  = pwd[0][c];
            end
            for (int c = 0; c < 2; c++) begin
                ifb.i_req[c] = pend[1][c];
                ifb.i_we[c]  = pwe[1][c];
                ifb.i_addr[c*10 +: 10] = padr[1][c];
                ifb.i_wdata[c*8 +: 8]  = pwd[1][c];
            end
            @(negedge clk);
            model_step(0, 3, 1, 0, ifa.i_req, ifa.i_we, ifa.i_addr, ifa.i_wdata,
                       ifa.o_gnt, ifa.o_rvalid, ifa.o_rdata,
                       ifa.o_mem_we, ifa.o_mem_addr, ifa.o_mem_wdata);
            model_step(1, 2, 0, 1, {1'b0, ifb.i_req}, {1'b0, ifb.i_we},
                       {10'h0, ifb.i_addr}, {8'h0, ifb.i_wdata},
                       {1'b0, ifb.o_gnt}, {1'b0, ifb.o_rvalid}, ifb.o_rdata,
                       ifb.o_mem_we, ifb.o_mem_addr, ifb.o_mem_wdata);
            cyc++;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ice51_mem_arb.md
# ice51_mem_arb

Parametrised N-channel arbiter that shares one single-port synchronous SRAM (one-cycle read latency) between several requesters: the ice51 core, a UART code loader and future DMA. It replaces fixed point-to-point core/memory wiring with a bus that can sit in front of any memory instance in the ice51 top level. It adds selectable fixed-priority or round-robin arbitration, an optional output pipeline stage, and per-channel read-return signalling.

## Interface
Parameters:
- NUM_CH, 2, number of requesting channels (1..8)
- ADDR_W, 10, memory address width
- DATA_W, 8, memory data width
- MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round robin
- PIPE, 0, 0 = memory-side outputs combinational, 1 = registered

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_nrst  in  1  asynchronous active-low reset
- i_req  in  NUM_CH  per-channel request, held until granted
- i_we  in  NUM_CH  per-channel write enable, qualified by i_req
- i_addr  in  NUM_CH*ADDR_W  channel c at bits [c*ADDR_W +: ADDR_W]
- i_wdata  in  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- o_gnt  out  NUM_CH  one-hot grant, combinational
- o_rvalid  out  NUM_CH  one-hot read-data-valid pulse
- o_rdata  out  DATA_W  shared read data, valid where o_rvalid is set
- o_mem_we  out  1  to memory
- o_mem_addr  out  ADDR_W  to memory
- o_mem_wdata  out  DATA_W  to memory
- i_mem_rdata  in  DATA_W  from memory, one cycle after address sampled

## Operation
- Transfer occurs in any cycle where i_req[c] and o_gnt[c] are both high; at most one o_gnt bit high per cycle; o_gnt is zero when i_req is zero.
- MODE 0: grant the lowest-indexed requesting channel.
- MODE 1: search from pointer ptr upward, wrapping at NUM_CH-1 to 0; grant the first requesting channel. After a grant to channel w, ptr <= (w+1) mod NUM_CH. ptr unchanged in cycles with no grant.
- Memory side carries the granted channel's we/addr/wdata; with no grant, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0.
- Reads (granted, i_we=0) schedule an o_rvalid pulse for that channel; writes never produce o_rvalid.
- o_rdata = i_mem_rdata passthrough; the tag pipeline records which channel owns each returning read.
- Requester must keep i_we/i_addr/i_wdata stable while i_req high and ungranted; dropping i_req before grant is permitted (request withdrawn, nothing issued).
- NUM_CH=1: o_gnt = i_req, ptr is constant 0.

## Timing
- Grant: combinational, same cycle as request.
- PIPE=0: memory signals combinational from grant; memory samples at edge N; o_rvalid[c] high in cycle N+1.
- PIPE=1: memory signals registered at edge N, memory samples at edge N+1; o_rvalid[c] high in cycle N+2. Back-to-back grants every cycle sustained in both modes (throughput 1 transfer/cycle).
- o_rvalid is a single-cycle pulse per read; consecutive reads give consecutive pulses, possibly to different channels.
- Reset (async, i_nrst low): ptr=0, o_rvalid=0, registered memory outputs (PIPE=1) = 0, tag pipeline cleared. Reads in flight at reset are discarded, no o_rvalid after release. o_gnt stays combinational from i_req during reset but no state advances; o_mem_we forced 0 during reset.
- Same-address write followed by read on the next cycle returns new data (memory ordering preserved; no reordering inside the arbiter).

## Test plan
- Single read, PIPE=0: write 0xA5 to addr 0x012 on ch0, then read -> o_gnt[0] same cycle, o_rvalid=2'b01 one cycle after read grant, o_rdata=0xA5.
- Round robin, MODE 1, NUM_CH=3, all i_req high for 6 cycles -> grant order 0,1,2,0,1,2; ptr wraps.
- Fixed priority, MODE 0, ch0 and ch1 both requesting continuously -> ch1 never granted until ch0 drops i_req; then ch1 granted same cycle.
- PIPE=1 back-to-back reads ch1 addr 0x3FF then ch0 addr 0x000 -> o_rvalid[1] at +2 cycles, o_rvalid[0] at +3, data matches preloaded values.
- Reset mid-read: grant read, assert i_nrst low before return -> o_rvalid stays 0, ptr=0 after release, first grant with all requesting goes to ch0.
- Idle and withdrawal: i_req=0 -> o_mem_we=0, o_mem_addr=0; request raised then dropped while another channel granted -> no access issued for withdrawn channel.
